// File: rtl/load_store_unit.sv
// load_store_unit: sequences one RV32I load or store per start pulse onto a
// simple req/ack memory port. It forms byte enables, replicates store data,
// extracts and extends the load lane, and aborts an access that gets no ack
// within TIMEOUT request cycles.
// Optional build macro: MISALIGN_TRAP_EN. When defined, misaligned half/word
// accesses are rejected. When undefined, the access is forced to natural
// alignment.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] DataOut,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic [0:0]  mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } state_t;

`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP_EN_C = 1'b1;
`else
    localparam logic TRAP_EN_C = 1'b0;
`endif

    // Last counter value that is still allowed to wait for an ack.
    localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT - 32'd1);

    // Command legality. Misalignment only counts when trapping is built in.
    function automatic logic cmd_valid(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        logic mis;
        ok = rd ^ wr;
        case (f3)
            3'b011, 3'b110, 3'b111: ok = 1'b0;
            3'b100, 3'b101:         ok = ok & ~wr;
            default:                ok = ok;
        endcase
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return ok & ~(mis & TRAP_EN_C);
    endfunction

    // Byte enables. Loads always fetch the whole word.
    function automatic logic [3:0] byte_en(input logic wr, input logic [2:0] f3,
                                           input logic [1:0] lo);
        logic [3:0] be;
        if (!wr) begin
            be = 4'b1111;
        end else begin
            case (f3[1:0])
                2'b00:   be = 4'b0001 << lo;
                2'b01:   be = 4'b0011 << {lo[1], 1'b0};
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Store data is replicated across every lane so the byte enables pick it.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Load lane selection followed by sign or zero extension.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'h000000, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'h0000, h};
            default: res = rd;
        endcase
        return res;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_next_s;
    logic        accept_s;
    logic        cmd_valid_s;
    logic        we_next_s;
    logic        is_load_r;
    logic [2:0]  funct3_r;
    logic [1:0]  lane_r;
    logic [31:0] data_out_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [3:0]  mem_be_r;
    logic [31:0] mem_wdata_r;

    assign cmd_valid_s = cmd_valid(MemRead, MemWrite, funct3, addr[1:0]);
    assign we_next_s   = accept_s ? MemWrite : ~is_load_r;

    // Next-state, timeout counter and accept decision.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (cmd_valid_s) begin
                        state_next_s = REQ;
                        cnt_next_s   = 8'd0;
                        accept_s     = 1'b1;
                    end else begin
                        state_next_s = ERR;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (mem_ack[0]) begin
                    state_next_s = DONE;
                end else if (cnt_r == TO_LAST_C) begin
                    state_next_s = ERR;
                end else begin
                    cnt_next_s = cnt_r + 8'd1;
                end
            end
            DONE:    state_next_s = IDLE;
            ERR:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Access capture: the request fields are frozen on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            is_load_r   <= 1'b0;
            funct3_r    <= 3'b000;
            lane_r      <= 2'b00;
        end else if (accept_s) begin
            mem_addr_r  <= {addr[31:2], 2'b00};
            mem_be_r    <= byte_en(MemWrite, funct3, addr[1:0]);
            mem_wdata_r <= MemWrite ? store_data(funct3, wdata) : 32'h0000_0000;
            is_load_r   <= MemRead;
            funct3_r    <= funct3;
            lane_r      <= addr[1:0];
        end
    end

    // Registered status and request strobes, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
        end else begin
            busy_r    <= (state_next_s != IDLE);
            done_r    <= (state_next_s == DONE);
            err_r     <= (state_next_s == ERR);
            mem_req_r <= (state_next_s == REQ);
            mem_we_r  <= (state_next_s == REQ) & we_next_s;
        end
    end

    // Load result, captured only when a load is acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r <= 32'h0000_0000;
        end else if ((state_r == REQ) && mem_ack[0] && is_load_r) begin
            data_out_r <= load_extract(funct3_r, lane_r, mem_rdata);
        end
    end

    assign DataOut   = data_out_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the stimulus pushes expected
// responses, and a monitor pops and compares them on every done/err pulse.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] DataOut;
    logic        busy, done, err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic [0:0]  mem_ack = 1'b0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .addr(addr), .wdata(wdata), .DataOut(DataOut),
        .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        bit          has_req;
        int          req_cycles;
        logic [31:0] maddr;
        logic [3:0]  be;
        bit          we;
        logic [31:0] mwdata;
        int          resp_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    logic [31:0] model_data = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference load value, from the lane/extension rules.
    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] r);
        logic [31:0] b, h;
        b = (r >> (8 * lo)) & 32'h0000_00FF;
        h = (r >> (16 * lo[1])) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return r;
        endcase
    endfunction

    // Memory responder: ack in REQ cycle number ack_delay, random ack when idle.
    initial begin : responder
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                mem_ack = (k == ack_delay) ? 1'b1 : 1'b0;
                k++;
            end else begin
                mem_ack = ($urandom_range(3) == 0) ? 1'b1 : 1'b0;
                k = 0;
            end
        end
    end

    // Monitor: track the request phase and compare each response against the queue.
    initial begin : monitor
        bit          seen, stable;
        int          n;
        logic [31:0] a0, wd0;
        logic [3:0]  be0;
        logic        we0;
        exp_t        e;
        seen = 0; stable = 1; n = 0;
        a0 = 0; wd0 = 0; be0 = 0; we0 = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                seen = 0; stable = 1; n = 0;
            end else begin
                if (mem_req === 1'b1) begin
                    if (!seen) begin
                        seen = 1; a0 = mem_addr; be0 = mem_be; wd0 = mem_wdata; we0 = mem_we;
                    end else if (mem_addr !== a0 || mem_be !== be0 || mem_wdata !== wd0 || mem_we !== we0) begin
                        stable = 0;
                    end
                    n++;
                end
                if (done === 1'b1 || err === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_response: done=%b err=%b with nothing pending", done, err);
                    end else begin
                        e = sb_q.pop_front();
                        check("resp_kind", {30'd0, err, done}, e.is_err ? 32'd2 : 32'd1);
                        check("busy_with_pulse", {31'd0, busy}, 32'd1);
                        check("data_out", DataOut, e.data);
                        check("resp_cycle", cyc, e.resp_cyc);
                        check("req_seen", {31'd0, seen}, {31'd0, e.has_req});
                        if (e.has_req) begin
                            check("req_cycles", n, e.req_cycles);
                            check("mem_addr", a0, e.maddr);
                            check("mem_be", {28'd0, be0}, {28'd0, e.be});
                            check("mem_we", {31'd0, we0}, {31'd0, e.we});
                            if (e.we) check("mem_wdata", wd0, e.mwdata);
                            check("req_stable", {31'd0, stable}, 32'd1);
                        end
                    end
                    seen = 0; stable = 1; n = 0;
                end
            end
        end
    end

    // Issue one access at a negedge with the DUT idle; wait for it to finish.
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int d, input logic [31:0] rdat);
        exp_t e;
        bit   ok, mis;
        int   guard;
        ok  = (rd != wr) && !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && !(wr && f3 > 3'd2);
        mis = 0;
`ifdef MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) mis = 1;
        if (f3 == 3'd2 && a[1:0] != 2'd0) mis = 1;
`endif
        ok = ok && !mis;
        e.resp_cyc   = cyc + 1;
        e.has_req    = ok;
        e.we         = wr;
        e.maddr      = a & 32'hFFFF_FFFC;
        e.is_err     = 1;
        e.req_cycles = 0;
        e.be         = 4'hF;
        e.mwdata     = wd;
        if (ok) begin
            if (wr) begin
                if (f3 == 3'd0) begin
                    e.be = 4'(32'd1 << a[1:0]);
                    e.mwdata = {24'd0, wd[7:0]} * 32'h0101_0101;
                end else if (f3 == 3'd1) begin
                    e.be = a[1] ? 4'hC : 4'h3;
                    e.mwdata = {16'd0, wd[15:0]} * 32'h0001_0001;
                end
            end
            if (d >= TO) begin
                e.req_cycles = TO;
                e.resp_cyc += TO;
            end else begin
                e.is_err = 0;
                e.req_cycles = d + 1;
                e.resp_cyc += d + 1;
                if (rd) model_data = load_value(f3, a[1:0], rdat);
            end
        end
        e.data = model_data;
        ack_delay = d;
        mem_rdata = rdat;
        MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        guard = 0;
        while (busy === 1'b1 && guard < 60) begin
            start = ($urandom_range(3) == 0);
            MemRead = 1'($urandom); MemWrite = 1'($urandom); funct3 = 3'($urandom);
            addr = $urandom; wdata = $urandom;
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        if (busy === 1'b1) begin
            checks++; failures++;
            $display("FAIL idle_wait: busy still 1 after %0d cycles, required 0", guard);
        end
    endtask

    initial begin : stim
        bit          rd, wr;
        logic [2:0]  f3;
        int          d, sel;
        logic [2:0]  legal [5];
        legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;

        repeat (3) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_data_out", DataOut, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 0, 32'h0);
        issue(1'b1, 1'b0, 3'd0, 32'h203, 32'h0, 1, 32'h80FF1234);
        issue(1'b1, 1'b0, 3'd4, 32'h203, 32'h0, 0, 32'h80FF1234);
        issue(1'b0, 1'b1, 3'd1, 32'h002, 32'h0000ABCD, 2, 32'h0);
        issue(1'b1, 1'b0, 3'd2, 32'h010, 32'h0, 255, 32'h11112222);
        issue(1'b1, 1'b0, 3'd2, 32'h006, 32'h0, 0, 32'hCAFEF00D);
        issue(1'b1, 1'b0, 3'd1, 32'h00B, 32'h0, 0, 32'h8001_7F02);
        issue(1'b1, 1'b0, 3'd2, 32'h008, 32'h0, 15, 32'h12345678);
        issue(1'b1, 1'b1, 3'd2, 32'h020, 32'h0, 0, 32'h0);
        issue(1'b0, 1'b0, 3'd2, 32'h020, 32'h0, 0, 32'h0);
        issue(1'b0, 1'b1, 3'd4, 32'h030, 32'h55, 0, 32'h0);
        issue(1'b1, 1'b0, 3'd3, 32'h030, 32'h0, 0, 32'h0);

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(9);
            if (sel < 5)      begin rd = 1; wr = 0; end
            else if (sel < 9) begin rd = 0; wr = 1; end
            else              begin rd = 1'($urandom); wr = rd; end
            f3 = ($urandom_range(4) == 0) ? 3'($urandom) : legal[$urandom_range(4)];
            sel = $urandom_range(9);
            if (sel < 6)       d = $urandom_range(3);
            else if (sel < 8)  d = $urandom_range(14, 4);
            else if (sel == 8) d = 15;
            else               d = 16 + $urandom_range(40);
            issue(rd, wr, f3, $urandom, $urandom, d, $urandom);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        // Reset in the middle of a request phase.
        issue(1'b1, 1'b0, 3'd2, 32'h040, 32'h0, 0, 32'hA5A5_5A5A);
        ack_delay = 255;
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'd2; addr = 32'h080; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data_out", DataOut, 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        sb_q.delete();
        model_data = 32'd0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        issue(1'b1, 1'b0, 3'd5, 32'h0C2, 32'h0, 1, 32'h9ABC_0123);
        issue(1'b0, 1'b1, 3'd0, 32'h0C1, 32'h0000_00E7, 0, 32'h0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the number of REQ-state cycles without mem_ack before an access aborts (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, the access request from control, sampled only in IDLE.
REQ-005 SHALL have ports MemRead and MemWrite, input, 1 each, the access type.
REQ-006 SHALL have port funct3, input, 3, the RV32I width/sign code.
REQ-007 SHALL have port addr, input, 32, the byte address (ALU rslt).
REQ-008 SHALL have port wdata, input, 32, the store data (rs2).
REQ-009 SHALL have port DataOut, output, 32, the registered load result feeding the writeback mux.
REQ-010 SHALL have ports busy, done and err, output, 1 each: busy = access in progress; done = one-cycle success pulse; err = one-cycle failure pulse.
REQ-011 SHALL have ports mem_req, mem_we, mem_addr[31:0], mem_be[3:0] and mem_wdata[31:0], output, forming the memory request.
REQ-012 SHALL have ports mem_rdata[31:0] and mem_ack[0:0], input, forming the memory response.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, DONE and ERR.
REQ-014 SHALL make the following FSM transitions:
- IDLE -> REQ on start with a valid command.
- IDLE -> ERR on start with an invalid command.
- REQ -> DONE on mem_ack.
- REQ -> ERR on timeout.
- DONE or ERR -> IDLE unconditionally.
REQ-015 SHALL treat a command as invalid when MemRead==MemWrite, funct3 is 011/110/111, a store funct3 is >010, or misalignment occurs (see REQ-030).
REQ-016 SHALL register addr, wdata, funct3 and the access type on the accepting edge; later input changes do not affect the access.
REQ-017 SHALL assert mem_req in REQ only, with mem_addr = {addr[31:2],2'b00} and mem_we = store.
REQ-018 SHALL hold mem_req, mem_addr, mem_be, mem_wdata and mem_we stable in REQ until mem_ack.
REQ-019 SHALL set mem_be as follows:
- SB: 4'b0001<<addr[1:0].
- SH: 4'b0011<<{addr[1],1'b0}.
- SW: 4'b1111.
- Loads: 4'b1111.
REQ-020 SHALL replicate mem_wdata: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
REQ-021 SHALL select the load lane from mem_rdata by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes 32 bits.
REQ-022 SHALL capture DataOut on the mem_ack edge for loads; DataOut holds its value until the next completed load (stores and errors leave it unchanged).
REQ-023 SHALL assert done for exactly the one cycle in DONE, and err for exactly the one cycle in ERR.
REQ-024 SHALL assert busy in REQ, DONE and ERR, and deassert it in IDLE.
REQ-025 SHALL give a load latency with zero-wait memory (ack in the first REQ cycle) of start edge to done = 2 cycles.
REQ-026 SHALL count a timeout counter from 0 on REQ entry, incrementing each REQ cycle without ack.
- When the count reaches TIMEOUT-1 with no ack, the next state is ERR.
- mem_ack arriving in the same cycle as the timeout wins (DONE).
REQ-027 SHALL ignore start outside IDLE, with no queueing.
REQ-028 SHALL ignore mem_ack outside REQ.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-access:
- Force IDLE immediately (asynchronously).
- Clear DataOut, the counter, mem_addr, mem_be and mem_wdata to 0.
- Drive mem_req, mem_we, busy, done and err to 0.
- Resume operation on the first clk edge after rst_n rises.

Configuration
REQ-030 SHALL, with macro MISALIGN_TRAP_EN defined:
- Treat LH/LHU/SH with addr[0]=1 as invalid (ERR, no mem_req).
- Treat LW/SW with addr[1:0]!=0 as invalid (ERR, no mem_req).
REQ-031 SHALL, with MISALIGN_TRAP_EN undefined:
- Never flag misalignment.
- Ignore addr[0] for halfword accesses and addr[1:0] for word accesses (naturally aligned access issued).

Verification
REQ-032 SHALL cover: SW addr=0x104, wdata=0xDEADBEEF, immediate ack -> mem_addr=0x104, be=1111, wdata=0xDEADBEEF, done 2 cycles after start.
REQ-033 SHALL cover: LB addr=0x203, mem_rdata=0x80FF1234 -> DataOut=0xFFFFFF80; LBU same -> 0x00000080.
REQ-034 SHALL cover: SH addr=0x002, wdata=0x0000ABCD -> be=1100, mem_wdata=0xABCDABCD.
REQ-035 SHALL cover: load with no ack, TIMEOUT=16 -> mem_req high 16 cycles, then err pulse, DataOut unchanged.
REQ-036 SHALL cover: LW addr=0x006 -> err with no mem_req (MISALIGN_TRAP_EN defined); mem_addr=0x004 and done (undefined).
REQ-037 SHALL cover: rst_n low during REQ -> mem_req and busy 0 within the same cycle, DataOut=0, next start serviced normally.
